// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [31:0] LSU_DMEM_BASE = 32'h8000_0000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] DT_BYTE = 2'd0;
    localparam logic [1:0] DT_HALF = 2'd1;
    localparam logic [1:0] DT_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    // One data-memory transaction as driven onto the port.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dt;
    } mem_txn_t;

    // Request as latched at acceptance, including its transaction plan.
    typedef struct packed {
        logic        sgn;
        logic        split;
        logic        bytewise;
        logic [2:0]  size;
        logic [1:0]  off;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Store transaction k of a request: one lane-aligned write, or byte k of a split store.
    function automatic mem_txn_t store_txn(input lsu_req_t r, input logic [1:0] k);
        mem_txn_t t;
        t.addr  = r.addr;
        t.wdata = '0;
        t.dt    = DT_BYTE;
        if (r.bytewise) begin
            t.addr  = r.addr + 32'(k);
            t.wdata = {24'b0, 8'(r.wdata >> {k, 3'b000})};
        end else begin
            case (r.size)
                3'd1: t.wdata = {24'b0, r.wdata[7:0]};
                3'd2: begin
                    t.wdata = {16'b0, r.wdata[15:0]};
                    t.dt    = DT_HALF;
                end
                default: begin
                    t.wdata = r.wdata;
                    t.dt    = DT_WORD;
                end
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline request/response and data-memory port bundle of the load/store unit.
interface dmem_lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  mem_datatype;
    logic        memread;
    logic        memwrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Pipeline plus data memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, busy, resp_valid, resp_err, resp_rdata,
               mem_datatype, memread, memwrite, mem_addr, mem_wdata
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, busy, resp_valid, resp_err, resp_rdata,
               mem_datatype, memread, memwrite, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts bytes [off .. off+size-1] of a two-word load buffer and extends them to 32 bits.
module lsu_load_align (
    input  logic [63:0] data_buf,
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        sgn,
    output logic [31:0] result_c
);

    logic [31:0] shifted;

    assign shifted = 32'(data_buf >> {off, 3'b000});

    always_comb begin
        case (size)
            3'd1:    result_c = {{24{sgn & shifted[7]}}, shifted[7:0]};
            3'd2:    result_c = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: result_c = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: turns RISC-V loads/stores into data-memory transactions,
// splitting misaligned accesses and stalling the pipeline until the response.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = LSU_DMEM_BASE
) (
    input logic       clk,
    input logic       reset,
    dmem_lsu_if.slave bus
);

    localparam logic [2:0] IDLE = 3'(ST_IDLE);
    localparam logic [2:0] RD   = 3'(ST_RD);
    localparam logic [2:0] WAIT = 3'(ST_WAIT);
    localparam logic [2:0] WR   = 3'(ST_WR);
    localparam logic [2:0] RESP = 3'(ST_RESP);

    logic [2:0]  state, state_n;
    lsu_req_t    req_q, req_n;
    lsu_req_t    dec;
    logic        dec_err;
    logic        dec_legal;
    logic        dec_below;
    logic [32:0] dec_last;
    logic [1:0]  idx_q, idx_n;
    logic [63:0] data_buf_q, data_buf_n, cap_buf;
    logic [31:0] load_result_c;
    mem_txn_t    st_first, st_next;

    logic        memread_q, memread_n;
    logic        memwrite_q, memwrite_n;
    logic [1:0]  dt_q, dt_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        resp_valid_q, resp_valid_n;
    logic        resp_err_q, resp_err_n;
    logic [31:0] rdata_q, rdata_n;

    // Request decode: size, signedness, transaction plan and error check.
    always_comb begin
        dec       = '0;
        dec.addr  = bus.req_addr;
        dec.wdata = bus.req_wdata;
        dec.off   = bus.req_addr[1:0];
        dec.sgn   = ~bus.req_funct3[2];
        case (bus.req_funct3[1:0])
            2'b00:   dec.size = 3'd1;
            2'b01:   dec.size = 3'd2;
            default: dec.size = 3'd4;
        endcase
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: dec_legal = 1'b1;
            F3_BU, F3_HU:     dec_legal = ~bus.req_we;
            default:          dec_legal = 1'b0;
        endcase
        dec.split    = (3'(dec.off) + dec.size) > 3'd4;
        dec.bytewise = (dec.size != 3'd1) && (dec.off != 2'd0);
        dec_last     = {1'b0, bus.req_addr} + 33'(dec.size) - 33'd1;
        dec_below    = bus.req_addr < DMEM_BASE;
        // MMIO/ROM only takes aligned words; nothing may straddle the RAM base or wrap.
        dec_err = ~dec_legal || dec_last[32]
                || (dec_below && (dec_last[31:0] >= DMEM_BASE))
                || (dec_below && ((dec.size != 3'd4) || (dec.off != 2'd0)));
    end

    assign st_first = store_txn(dec, 2'd0);
    assign st_next  = store_txn(req_q, idx_q + 2'd1);

    // Load buffer as it stands after this cycle's read data is captured.
    always_comb begin
        cap_buf = data_buf_q;
        if (state == WAIT) begin
            if (idx_q == 2'd0) cap_buf[31:0]  = bus.mem_rdata;
            else               cap_buf[63:32] = bus.mem_rdata;
        end
    end

    lsu_load_align u_align (
        .data_buf (cap_buf),
        .off      (req_q.off),
        .size     (req_q.size),
        .sgn      (req_q.sgn),
        .result_c (load_result_c)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_n      = state;
        req_n        = req_q;
        idx_n        = idx_q;
        data_buf_n   = cap_buf;
        memread_n    = 1'b0;
        memwrite_n   = 1'b0;
        dt_n         = DT_BYTE;
        addr_n       = '0;
        wdata_n      = '0;
        resp_valid_n = 1'b0;
        resp_err_n   = 1'b0;
        rdata_n      = '0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    req_n      = dec;
                    idx_n      = '0;
                    data_buf_n = '0;
                    if (dec_err) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (!bus.req_we) begin
                        state_n   = RD;
                        memread_n = 1'b1;
                        dt_n      = DT_WORD;
                        addr_n    = {dec.addr[31:2], 2'b00};
                    end else begin
                        state_n    = WR;
                        memwrite_n = 1'b1;
                        dt_n       = st_first.dt;
                        addr_n     = st_first.addr;
                        wdata_n    = st_first.wdata;
                    end
                end
            end
            RD: state_n = WAIT;
            WAIT: begin
                if (req_q.split && (idx_q == 2'd0)) begin
                    state_n   = RD;
                    idx_n     = 2'd1;
                    memread_n = 1'b1;
                    dt_n      = DT_WORD;
                    addr_n    = {req_q.addr[31:2], 2'b00} + 32'd4;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    rdata_n      = load_result_c;
                end
            end
            WR: begin
                if (req_q.bytewise && ((3'(idx_q) + 3'd1) < req_q.size)) begin
                    idx_n      = idx_q + 2'd1;
                    memwrite_n = 1'b1;
                    dt_n       = st_next.dt;
                    addr_n     = st_next.addr;
                    wdata_n    = st_next.wdata;
                end else begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            idx_q        <= '0;
            data_buf_q   <= '0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            dt_q         <= DT_BYTE;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state        <= state_n;
            req_q        <= req_n;
            idx_q        <= idx_n;
            data_buf_q   <= data_buf_n;
            memread_q    <= memread_n;
            memwrite_q   <= memwrite_n;
            dt_q         <= dt_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            resp_valid_q <= resp_valid_n;
            resp_err_q   <= resp_err_n;
            rdata_q      <= rdata_n;
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.memread      = memread_q;
    assign bus.memwrite     = memwrite_q;
    assign bus.mem_datatype = dt_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: a byte-addressed reference model predicts every cycle of the port.
module tb_dmem_lsu;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_lsu_if bus();

    dmem_lsu #(.DMEM_BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        bit        rd;
        bit        wr;
        bit        quiet;
        bit        rv;
        bit        err;
        bit        busy;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] wmask;
        bit [31:0] rdata;
        bit [1:0]  dt;
    } exp_t;

    exp_t      exp_q[$];
    bit [7:0]  env_mem [bit [31:0]];
    bit [7:0]  ref_mem [bit [31:0]];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    int        resp_cnt = 0;
    bit        chk_en   = 1'b0;
    bit [31:0] last_rdata;
    bit        last_err;

    function automatic bit [7:0] init_byte(input bit [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic bit [7:0] env_rd(input bit [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_byte(a);
    endfunction

    function automatic bit [7:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic void preload(input bit [31:0] a, input bit [31:0] w);
        for (int k = 0; k < 4; k++) begin
            env_mem[a + 32'(k)] = w[8*k +: 8];
            ref_mem[a + 32'(k)] = w[8*k +: 8];
        end
    endfunction

    function automatic int size_of(input bit [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    // Byte-level load semantics straight from the reference memory.
    function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] a);
        int        size = size_of(f3);
        bit [31:0] v    = 32'd0;
        for (int k = 0; k < size; k++) v |= 32'(ref_rd(a + 32'(k))) << (8 * k);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
        return v;
    endfunction

    function automatic exp_t rec_idle();
        exp_t r = '0;
        r.quiet = 1'b1;
        return r;
    endfunction

    function automatic exp_t rec_busy(input bit rd, input bit wr, input bit [31:0] a,
                                      input bit [31:0] wd, input bit [31:0] m, input bit [1:0] dt);
        exp_t r = '0;
        r.busy = 1'b1; r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd; r.wmask = m; r.dt = dt;
        return r;
    endfunction

    function automatic exp_t rec_resp(input bit err, input bit [31:0] rdata);
        exp_t r = '0;
        r.busy = 1'b1; r.quiet = 1'b1; r.rv = 1'b1; r.err = err; r.rdata = rdata;
        return r;
    endfunction

    // Pushes the expected port activity for cycles 1..n after acceptance; returns n.
    function automatic int plan(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        int        size  = size_of(f3);
        int        start = exp_q.size();
        bit [63:0] last  = {32'd0, a} + 64'(size) - 64'd1;
        bit        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        bit        err;
        bit [31:0] wa    = {a[31:2], 2'b00};
        err = !legal || last > 64'hFFFF_FFFF
            || (a < BASE && last >= 64'(BASE))
            || (a < BASE && (size != 4 || a[1:0] != 2'd0));
        if (err) begin
            exp_q.push_back(rec_resp(1'b1, 32'd0));
        end else if (!we) begin
            exp_q.push_back(rec_busy(1'b1, 1'b0, wa, 32'd0, 32'd0, 2'd2));
            exp_q.push_back(rec_busy(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0));
            if (int'(a[1:0]) + size > 4) begin
                exp_q.push_back(rec_busy(1'b1, 1'b0, wa + 32'd4, 32'd0, 32'd0, 2'd2));
                exp_q.push_back(rec_busy(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'd0));
            end
            exp_q.push_back(rec_resp(1'b0, model_load(f3, a)));
        end else begin
            if (size == 1 || a[1:0] == 2'd0) begin
                exp_q.push_back(rec_busy(1'b0, 1'b1, a, wd,
                    (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF,
                    (size == 1) ? 2'd0 : (size == 2) ? 2'd1 : 2'd2));
            end else begin
                for (int k = 0; k < size; k++)
                    exp_q.push_back(rec_busy(1'b0, 1'b1, a + 32'(k), 32'(wd[8*k +: 8]), 32'hFF, 2'd0));
            end
            for (int k = 0; k < size; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
            exp_q.push_back(rec_resp(1'b0, 32'd0));
        end
        return exp_q.size() - start;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, expv);
        end
    endtask

    // Data memory: registered read data, writes at the edge by datatype.
    bit [31:0] mem_wa;
    int        mem_nb;
    always @(posedge clk) begin
        mem_wa = {bus.mem_addr[31:2], 2'b00};
        if (bus.memread)
            bus.mem_rdata <= {env_rd(mem_wa + 32'd3), env_rd(mem_wa + 32'd2),
                              env_rd(mem_wa + 32'd1), env_rd(mem_wa)};
        if (bus.memwrite) begin
            mem_nb = (bus.mem_datatype == 2'd0) ? 1 : (bus.mem_datatype == 2'd1) ? 2 : 4;
            for (int k = 0; k < mem_nb; k++) env_mem[bus.mem_addr + 32'(k)] = bus.mem_wdata[8*k +: 8];
        end
    end

    // Cycle-by-cycle comparison against the model schedule.
    exp_t e;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.resp_valid) begin
            resp_cnt++;
            last_rdata = bus.resp_rdata;
            last_err   = bus.resp_err;
        end
        if (chk_en) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : rec_idle();
            chk("memread",    32'(bus.memread),    32'(e.rd));
            chk("memwrite",   32'(bus.memwrite),   32'(e.wr));
            chk("resp_valid", 32'(bus.resp_valid), 32'(e.rv));
            chk("busy",       32'(bus.busy),       32'(e.busy));
            chk("req_ready",  32'(bus.req_ready),  32'(!e.busy));
            if (e.quiet) begin
                chk("quiet_addr",  bus.mem_addr,  32'd0);
                chk("quiet_wdata", bus.mem_wdata, 32'd0);
            end
            if (e.rd || e.wr) begin
                chk("mem_addr",     bus.mem_addr,          e.addr);
                chk("mem_datatype", 32'(bus.mem_datatype), 32'(e.dt));
            end
            if (e.wr) chk("mem_wdata", bus.mem_wdata & e.wmask, e.wdata & e.wmask);
            if (e.rv) begin
                chk("resp_err",   32'(bus.resp_err), 32'(e.err));
                chk("resp_rdata", bus.resp_rdata,    e.rdata);
            end
        end
    end

    task automatic drive_junk();
        bus.req_valid  = 1'($urandom_range(0, 1));
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom();
        bus.req_wdata  = $urandom();
    endtask

    task automatic issue(input bit we, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output int n);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        n = plan(we, f3, a, wd);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i < n) drive_junk();
            else       bus.req_valid = 1'b0;
        end
    endtask

    function automatic bit [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h7FFF_FFF8 + $urandom_range(0, 7);
            1:       return 32'hFFFF_FFF8 + $urandom_range(0, 7);
            2, 3:    return 32'h0010_0000 + $urandom_range(0, 15);
            default: return BASE + $urandom_range(0, 47);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int        n;
        int        rc;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] a;
        bit [31:0] wd;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        preload(32'h8000_0010, 32'hDEAD_BEEF);
        preload(32'h8000_0000, 32'h8011_2233);
        preload(32'h8000_0004, 32'h4433_2211);
        preload(32'h8000_0008, 32'h8877_6655);
        preload(32'h0010_0000, 32'h0126_077C);

        chk("model_lb",  model_load(3'b000, 32'h8000_0003), 32'hFFFF_FF80);
        chk("model_lbu", model_load(3'b100, 32'h8000_0003), 32'h0000_0080);
        chk("model_lw6", model_load(3'b010, 32'h8000_0006), 32'h6655_4433);

        issue(1'b0, 3'b010, 32'h8000_0010, 32'd0, n);
        chk("lw_cycles", 32'(n), 32'd3);
        chk("lw_data", last_rdata, 32'hDEAD_BEEF);
        issue(1'b0, 3'b000, 32'h8000_0003, 32'd0, n);
        chk("lb_data", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h8000_0003, 32'd0, n);
        chk("lbu_data", last_rdata, 32'h0000_0080);
        issue(1'b0, 3'b010, 32'h8000_0006, 32'd0, n);
        chk("split_cycles", 32'(n), 32'd5);
        chk("split_lw", last_rdata, 32'h6655_4433);
        issue(1'b0, 3'b001, 32'h8000_0007, 32'd0, n);
        chk("split_lh", last_rdata, 32'h0000_5544);
        issue(1'b1, 3'b010, 32'h8000_0005, 32'h1234_5678, n);
        chk("sw_split_cycles", 32'(n), 32'd5);
        issue(1'b0, 3'b010, 32'h8000_0004, 32'd0, n);
        chk("sw_readback", {8'd0, last_rdata[31:8]}, 32'h0034_5678);
        issue(1'b0, 3'b010, 32'h0010_0000, 32'd0, n);
        chk("mmio_lw", last_rdata, 32'h0126_077C);
        issue(1'b0, 3'b001, 32'h0010_0002, 32'd0, n);
        chk("mmio_lh_cycles", 32'(n), 32'd1);
        chk("mmio_lh_err", 32'(last_err), 32'd1);

        // Reset during the second read of a split load.
        rc = resp_cnt;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h8000_0006;
        n = plan(1'b0, 3'b010, 32'h8000_0006, 32'd0);
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        repeat (5) @(negedge clk);
        chk("rst_no_resp", 32'(resp_cnt), 32'(rc));

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = rand_addr();
            wd = $urandom();
            issue(we, f3, a, wd, n);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                bus.req_valid = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
